// File: rtl/pixie_video_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pixie_video_pkg
//  Purpose  : Shared raster timing constants, widths and types for the
//             pixie video back-end.
//  Revision : 1.0 - initial release
// ============================================================================
package pixie_video_pkg;

    localparam int H_W   = 7;
    localparam int V_W   = 9;
    localparam int DIV_W = 2;

    localparam int                CE_DIV   = 4;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CE_DIV - 1);

    localparam logic [H_W-1:0] H_TOTAL      = 7'd112;
    localparam logic [H_W-1:0] H_ACTIVE     = 7'd64;
    localparam logic [H_W-1:0] H_SYNC_START = 7'd80;
    localparam logic [H_W-1:0] H_SYNC_LEN   = 7'd8;

    localparam logic [V_W-1:0] V_TOTAL      = 9'd262;
    localparam logic [V_W-1:0] V_ACT_START  = 9'd78;
    localparam logic [V_W-1:0] V_ACTIVE     = 9'd128;
    localparam logic [V_W-1:0] V_SYNC_START = 9'd240;
    localparam logic [V_W-1:0] V_SYNC_LEN   = 9'd4;
    localparam logic [V_W-1:0] V_ALIGN      = 9'd76;

    localparam int LINE_BYTES = 8;

    typedef logic [2:0]     byte_idx_t;
    typedef logic [7:0]     pix_byte_t;
    typedef logic [H_W-1:0] h_cnt_t;
    typedef logic [V_W-1:0] v_cnt_t;

    // Bit 7 of a display byte is the leftmost pixel of its 8-pixel group.
    function automatic logic pixel_bit(input pix_byte_t b, input byte_idx_t col);
        return b[3'd7 - col];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixie_video_out_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixie_video_out_if
//  Purpose  : DMA-in / raster-out bundle between the CPU side and the video
//             back-end.
//  Revision : 1.0 - initial release
// ============================================================================
interface pixie_video_out_if;
    import pixie_video_pkg::*;

    logic      dma_valid;
    pix_byte_t dma_data;
    logic      frame_sync;

    logic      ce_pix;
    logic      HBlank;
    logic      HSync;
    logic      VBlank;
    logic      VSync;
    pix_byte_t video;
    logic      overflow;

    modport master (
        output dma_valid, dma_data, frame_sync,
        input  ce_pix, HBlank, HSync, VBlank, VSync, video, overflow
    );

    modport slave (
        input  dma_valid, dma_data, frame_sync,
        output ce_pix, HBlank, HSync, VBlank, VSync, video, overflow
    );

endinterface
`default_nettype wire

// File: rtl/pixie_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pixie_line_buffer
//  Purpose  : Two 8-byte banks; one is displayed while the other collects the
//             next line's DMA bytes. Swaps only when a full line was captured.
//  Revision : 1.0 - initial release
// ============================================================================
module pixie_line_buffer
    import pixie_video_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      i_line_end,
    input  wire logic      i_dma_valid,
    input  wire pix_byte_t i_dma_data,
    input  wire byte_idx_t i_rd_idx,
    output pix_byte_t      o_rd_byte,
    output logic           o_rd_valid,
    output logic           o_overflow
);

    pix_byte_t r_mem [2][LINE_BYTES];
    logic      r_sel;
    logic [1:0] r_valid;
    byte_idx_t r_wr_idx;
    logic      r_wfull;
    logic      r_overflow;

    logic      w_sel_next;
    logic      w_wr_bank;
    logic      w_full_eff;
    logic      w_accept;
    byte_idx_t w_idx;

    // A boundary takes effect before a coincident write, so the write sees the post-swap bank and index 0.
    always_comb begin
        w_sel_next = r_sel;
        w_idx      = r_wr_idx;
        w_full_eff = r_wfull;
        if (i_line_end) begin
            w_idx      = '0;
            w_full_eff = 1'b0;
            if (r_wfull) begin
                w_sel_next = ~r_sel;
            end
        end
        w_wr_bank = ~w_sel_next;
        w_accept  = i_dma_valid & ~w_full_eff;
    end

    // Bank selection, valid flags, write index and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel      <= 1'b0;
            r_valid    <= 2'b00;
            r_wr_idx   <= '0;
            r_wfull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= i_dma_valid & w_full_eff;
            if (i_line_end) begin
                r_sel <= w_sel_next;
                // Only the bank about to be displayed can be valid; a short line leaves it dark.
                if (w_sel_next) begin
                    r_valid <= {r_wfull, 1'b0};
                end else begin
                    r_valid <= {1'b0, r_wfull};
                end
            end
            if (w_accept) begin
                r_wr_idx <= w_idx + 3'd1;
                r_wfull  <= (w_idx == 3'd7);
            end else if (i_line_end) begin
                r_wr_idx <= '0;
                r_wfull  <= 1'b0;
            end
        end
    end

    // Byte storage; contents need no reset because the valid flags gate display.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_mem[w_wr_bank][w_idx] <= i_dma_data;
        end
    end

    assign o_rd_byte  = r_mem[r_sel][i_rd_idx];
    assign o_rd_valid = r_valid[r_sel];
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/pixie_video_out.sv
`default_nettype none
// ============================================================================
//  Module   : pixie_video_out
//  Purpose  : Pixie raster back-end: pixel divider, h/v timing, frame
//             alignment, line buffering and registered video/sync outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module pixie_video_out
    import pixie_video_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         reset,
    pixie_video_out_if.slave  bus
);

    logic [DIV_W-1:0] r_div;
    logic             r_ce_pix;
    h_cnt_t           r_h_cnt;
    v_cnt_t           r_v_cnt;
    logic             r_fs_pending;

    logic             r_ce_out;
    logic             r_hblank;
    logic             r_hsync;
    logic             r_vblank;
    logic             r_vsync;
    pix_byte_t        r_video;

    logic             w_line_end;
    logic             w_hblank;
    logic             w_hsync;
    logic             w_vblank;
    logic             w_vsync;
    logic             w_lit;
    pix_byte_t        w_rd_byte;
    logic             w_rd_valid;
    logic             w_overflow;

    assign w_line_end = r_ce_pix && (r_h_cnt == H_TOTAL - 7'd1);

    // Pixel-rate divider; ce_pix is a registered one-in-CE_DIV strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= '0;
            r_ce_pix <= 1'b0;
        end else begin
            r_ce_pix <= (r_div == DIV_LAST);
            r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end
    end

    // Raster counters with frame_sync snapping v_cnt to V_ALIGN on the next line boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_fs_pending <= 1'b0;
        end else begin
            if (r_ce_pix) begin
                if (w_line_end) begin
                    r_h_cnt <= '0;
                    if (r_fs_pending || bus.frame_sync) begin
                        r_v_cnt <= V_ALIGN;
                    end else if (r_v_cnt == V_TOTAL - 9'd1) begin
                        r_v_cnt <= '0;
                    end else begin
                        r_v_cnt <= r_v_cnt + 9'd1;
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + 7'd1;
                end
            end
            if (w_line_end) begin
                r_fs_pending <= 1'b0;
            end else if (bus.frame_sync) begin
                r_fs_pending <= 1'b1;
            end
        end
    end

    pixie_line_buffer u_line_buffer (
        .clk         (clk),
        .rst         (reset),
        .i_line_end  (w_line_end),
        .i_dma_valid (bus.dma_valid),
        .i_dma_data  (bus.dma_data),
        .i_rd_idx    (r_h_cnt[5:3]),
        .o_rd_byte   (w_rd_byte),
        .o_rd_valid  (w_rd_valid),
        .o_overflow  (w_overflow)
    );

    assign w_hblank = (r_h_cnt >= H_ACTIVE);
    assign w_hsync  = (r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_START + H_SYNC_LEN);
    assign w_vblank = !((r_v_cnt >= V_ACT_START) && (r_v_cnt < V_ACT_START + V_ACTIVE));
    assign w_vsync  = (r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_START + V_SYNC_LEN);
    assign w_lit    = !w_hblank && !w_vblank && w_rd_valid && pixel_bit(w_rd_byte, r_h_cnt[2:0]);

    // Output stage; ce_pix is delayed with the rest so every output stays aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ce_out <= 1'b0;
            r_hblank <= 1'b0;
            r_hsync  <= 1'b0;
            r_vblank <= 1'b0;
            r_vsync  <= 1'b0;
            r_video  <= 8'h00;
        end else begin
            r_ce_out <= r_ce_pix;
            r_hblank <= w_hblank;
            r_hsync  <= w_hsync;
            r_vblank <= w_vblank;
            r_vsync  <= w_vsync;
            r_video  <= w_lit ? 8'hFF : 8'h00;
        end
    end

    assign bus.ce_pix   = r_ce_out;
    assign bus.HBlank   = r_hblank;
    assign bus.HSync    = r_hsync;
    assign bus.VBlank   = r_vblank;
    assign bus.VSync    = r_vsync;
    assign bus.video    = r_video;
    assign bus.overflow = w_overflow;

endmodule
`default_nettype wire
